// File: rtl/sram_fb_writer.sv
// ============================================================================
// Module  : sram_fb_writer
// Brief   : FIFO-buffered pixel writer driving asynchronous-SRAM write cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_fb_writer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 1,
    parameter int FRAME_LAST = 19661
) (
    input  logic              clk_2M,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       overflow_cnt,
    output logic              range_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STB_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LAST);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(WE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_dq_q, sram_dq_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic [STB_W-1:0]    stb_cnt_q, stb_cnt_d;
    logic                frame_done_q, frame_done_d;
    logic [15:0]         ovf_q, ovf_d;
    logic                range_err_q, range_err_d;

    logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic              in_range;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    always_comb begin
        in_range               = (in_addr <= LAST_ADDR);
        push                   = in_valid && in_ready_q && in_range;
        pop                    = (count_q != '0) && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
        {head_addr, head_data} = fifo_mem[rd_ptr_q];

        state_d      = state_q;
        sram_addr_d  = sram_addr_q;
        sram_dq_d    = sram_dq_q;
        dq_oe_d      = dq_oe_q;
        ce_n_d       = ce_n_q;
        we_n_d       = we_n_q;
        stb_cnt_d    = stb_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_SETUP: begin
                state_d   = ST_STROBE;
                we_n_d    = 1'b0;
                stb_cnt_d = STB_LAST;
            end
            ST_STROBE: begin
                if (stb_cnt_q == '0) begin
                    state_d = ST_HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    stb_cnt_d = stb_cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                frame_done_d = (sram_addr_q == LAST_ADDR);
                state_d      = ST_IDLE;
                ce_n_d       = 1'b1;
                dq_oe_d      = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop from IDLE or HOLD starts the next write cycle on the same edge
        if (pop) begin
            state_d     = ST_SETUP;
            sram_addr_d = head_addr;
            sram_dq_d   = head_data;
            ce_n_d      = 1'b0;
            we_n_d      = 1'b1;
            dq_oe_d     = 1'b1;
        end

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        in_ready_d = (count_d != FULL_CNT);

        ovf_d = ovf_q;
        if (in_valid && !in_ready_q && in_range && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        range_err_d = range_err_q || (in_valid && !in_range);
    end

    always_ff @(posedge clk_2M) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            sram_addr_q  <= '0;
            sram_dq_q    <= '0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            stb_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= '0;
            range_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            sram_addr_q  <= sram_addr_d;
            sram_dq_q    <= sram_dq_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            we_n_q       <= we_n_d;
            stb_cnt_q    <= stb_cnt_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
            range_err_q  <= range_err_d;
        end
    end

    always_ff @(posedge clk_2M) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_addr, in_data};
        end
    end

    assign in_ready     = in_ready_q;
    assign sram_addr    = sram_addr_q;
    assign sram_dq_o    = sram_dq_q;
    assign sram_dq_oe   = dq_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_we_n    = we_n_q;
    assign busy         = (state_q != ST_IDLE) || (count_q != '0);
    assign frame_done   = frame_done_q;
    assign overflow_cnt = ovf_q;
    assign range_err    = range_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_fb_writer.sv
// ============================================================================
// Module  : tb_sram_fb_writer
// Brief   : Self-checking bench for sram_fb_writer against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_fb_writer;

    localparam int LAST = 19661;

    logic        clk_2M = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_addr = '0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [15:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        busy;
    logic        frame_done;
    logic [15:0] overflow_cnt;
    logic        range_err;

    int n_checks = 0;
    int n_pass   = 0;

    sram_fb_writer dut (
        .clk_2M      (clk_2M),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .sram_addr   (sram_addr),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_we_n   (sram_we_n),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow_cnt(overflow_cnt),
        .range_err   (range_err)
    );

    always #5 clk_2M = ~clk_2M;

    // Bus monitor: records each write at the start of its strobe and flags
    // a missing drive enable or address/data changing before HOLD.
    logic [31:0] obs_q[$];
    logic [31:0] cur_wr = '0;
    int          bus_err = 0;
    int          fd_cnt = 0;
    logic        we_prev = 1'b1;

    always @(negedge clk_2M) begin
        if (!sram_ce_n && !sram_we_n && we_prev) begin
            obs_q.push_back({sram_addr, sram_dq_o});
            cur_wr = {sram_addr, sram_dq_o};
            if (sram_dq_oe !== 1'b1) bus_err++;
        end
        if (!sram_ce_n && sram_we_n && !we_prev && ({sram_addr, sram_dq_o} !== cur_wr)) bus_err++;
        if (frame_done === 1'b1) fd_cnt++;
        we_prev = sram_we_n;
    end

    task automatic step();
        @(posedge clk_2M);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s drain: busy=%b after %0d cycles, required 0", name, busy, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({in_ready, busy, sram_ce_n, sram_we_n, sram_dq_oe, frame_done, range_err} !== 7'b1011000)
            $display("FAIL reset_flags: got %b required 1011000",
                     {in_ready, busy, sram_ce_n, sram_we_n, sram_dq_oe, frame_done, range_err});
        else n_pass++;
        n_checks++;
        if (sram_addr !== 16'h0) $display("FAIL reset_addr: got %h required 0000", sram_addr);
        else n_pass++;
        n_checks++;
        if (sram_dq_o !== 16'h0) $display("FAIL reset_dq: got %h required 0000", sram_dq_o);
        else n_pass++;
        n_checks++;
        if (overflow_cnt !== 16'h0) $display("FAIL reset_ovf: got %0d required 0", overflow_cnt);
        else n_pass++;
    endtask

    task automatic test_single_write();
        int base, err0;
        logic [2:0] exp_ctl [4];
        exp_ctl[0] = 3'b011; exp_ctl[1] = 3'b001; exp_ctl[2] = 3'b011;
        do_reset();
        base = obs_q.size();
        err0 = bus_err;
        in_valid = 1'b1; in_addr = 16'h0005; in_data = 16'h9249;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({sram_ce_n, busy} !== 2'b11) $display("FAIL single_pushed: ce_n,busy=%b required 11", {sram_ce_n, busy});
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({sram_ce_n, sram_we_n, sram_dq_oe} !== exp_ctl[c])
                $display("FAIL single_ctl[%0d]: ce_n,we_n,oe=%b required %b", c, {sram_ce_n, sram_we_n, sram_dq_oe}, exp_ctl[c]);
            else n_pass++;
            n_checks++;
            if ({sram_addr, sram_dq_o} !== 32'h0005_9249)
                $display("FAIL single_bus[%0d]: addr/dq=%h required 00059249", c, {sram_addr, sram_dq_o});
            else n_pass++;
        end
        step();
        n_checks++;
        if ({sram_ce_n, sram_we_n, sram_dq_oe, busy} !== 4'b1100)
            $display("FAIL single_idle: ce_n,we_n,oe,busy=%b required 1100", {sram_ce_n, sram_we_n, sram_dq_oe, busy});
        else n_pass++;
        n_checks++;
        if ((obs_q.size() - base) !== 1 || bus_err !== err0)
            $display("FAIL single_count: writes=%0d buserr=%0d required 1 and 0", obs_q.size() - base, bus_err - err0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        int base, ovf, saw_full, bad;
        do_reset();
        base = obs_q.size();
        ovf = 0; saw_full = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_addr  = 16'(i);
            in_data  = 16'($urandom);
            if (in_ready) exp_q.push_back({in_addr, in_data});
            else begin ovf++; saw_full = 1; end
            step();
        end
        in_valid = 1'b0;
        drain("b2b");
        n_checks++;
        if (saw_full !== 1) $display("FAIL b2b_ready_drop: in_ready never low, required low when full");
        else n_pass++;
        n_checks++;
        if (overflow_cnt !== 16'(ovf)) $display("FAIL b2b_ovf: got %0d required %0d", overflow_cnt, ovf);
        else n_pass++;
        n_checks++;
        if (obs_q.size() - base !== exp_q.size())
            $display("FAIL b2b_count: got %0d writes required %0d", obs_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
            if (obs_q[base + i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL b2b_order: %0d writes out of order or wrong, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_frame_done();
        int fd0;
        do_reset();
        fd0 = fd_cnt;
        in_valid = 1'b1; in_addr = 16'(LAST - 1); in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        drain("fd_prev");
        repeat (2) step();
        n_checks++;
        if (fd_cnt !== fd0) $display("FAIL fd_none: got %0d pulses for addr 19660 required 0", fd_cnt - fd0);
        else n_pass++;
        in_valid = 1'b1; in_addr = 16'(LAST); in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({sram_we_n, sram_ce_n, frame_done} !== 3'b100)
            $display("FAIL fd_hold: we_n,ce_n,fd=%b required 100", {sram_we_n, sram_ce_n, frame_done});
        else n_pass++;
        step();
        n_checks++;
        if ({frame_done, sram_ce_n} !== 2'b11) $display("FAIL fd_pulse: fd,ce_n=%b required 11", {frame_done, sram_ce_n});
        else n_pass++;
        step();
        n_checks++;
        if (frame_done !== 1'b0) $display("FAIL fd_width: got %b required 0", frame_done);
        else n_pass++;
        n_checks++;
        if (fd_cnt - fd0 !== 1) $display("FAIL fd_count: got %0d pulses required 1", fd_cnt - fd0);
        else n_pass++;
    endtask

    task automatic test_range();
        int base;
        do_reset();
        base = obs_q.size();
        in_valid = 1'b1; in_addr = 16'(LAST + 1); in_data = 16'h5555;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        n_checks++;
        if ({range_err, busy} !== 2'b10) $display("FAIL range_flag: range_err,busy=%b required 10", {range_err, busy});
        else n_pass++;
        n_checks++;
        if (overflow_cnt !== 16'h0) $display("FAIL range_ovf: got %0d required 0", overflow_cnt);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== base) $display("FAIL range_write: got %0d writes required 0", obs_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_reset_in_strobe();
        int base;
        do_reset();
        in_valid = 1'b1; in_addr = 16'h0ABC; in_data = 16'($urandom);
        step();
        in_valid = 1'b0;
        repeat (2) step();
        n_checks++;
        if (sram_we_n !== 1'b0) $display("FAIL rst_strobe_pre: we_n=%b required 0", sram_we_n);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if ({sram_we_n, sram_ce_n, sram_dq_oe, busy, in_ready} !== 5'b11001)
            $display("FAIL rst_strobe: we_n,ce_n,oe,busy,rdy=%b required 11001",
                     {sram_we_n, sram_ce_n, sram_dq_oe, busy, in_ready});
        else n_pass++;
        rst = 1'b0;
        base = obs_q.size();
        repeat (6) step();
        n_checks++;
        if (obs_q.size() !== base || busy !== 1'b0)
            $display("FAIL rst_strobe_lost: writes=%0d busy=%b required 0 and 0", obs_q.size() - base, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        int base, err0, fd0, ovf, rerr, nfd, bad;
        do_reset();
        base = obs_q.size(); err0 = bus_err; fd0 = fd_cnt;
        ovf = 0; rerr = 0; nfd = 0; bad = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom % 4) != 0;
            case ($urandom % 16)
                0:       in_addr = 16'($urandom_range(LAST + 1, 65535));
                1:       in_addr = 16'(LAST);
                default: in_addr = 16'($urandom_range(0, LAST));
            endcase
            in_data = 16'($urandom);
            if (in_valid) begin
                if (in_addr > 16'(LAST)) rerr = 1;
                else if (in_ready) begin
                    exp_q.push_back({in_addr, in_data});
                    if (in_addr == 16'(LAST)) nfd++;
                end else if (ovf < 65535) ovf++;
            end
            step();
        end
        in_valid = 1'b0;
        drain("rand");
        repeat (2) step();
        n_checks++;
        if (obs_q.size() - base !== exp_q.size())
            $display("FAIL rand_count: got %0d writes required %0d", obs_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
            if (obs_q[base + i] !== exp_q[i]) bad++;
        n_checks++;
        if (bad !== 0) $display("FAIL rand_data: %0d writes wrong, required 0", bad);
        else n_pass++;
        n_checks++;
        if (overflow_cnt !== 16'(ovf)) $display("FAIL rand_ovf: got %0d required %0d", overflow_cnt, ovf);
        else n_pass++;
        n_checks++;
        if (range_err !== 1'(rerr)) $display("FAIL rand_range: got %b required %0d", range_err, rerr);
        else n_pass++;
        n_checks++;
        if (fd_cnt - fd0 !== nfd) $display("FAIL rand_fd: got %0d pulses required %0d", fd_cnt - fd0, nfd);
        else n_pass++;
        n_checks++;
        if (bus_err !== err0) $display("FAIL rand_bus: %0d bus timing errors required 0", bus_err - err0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_frame_done();
        test_range();
        test_reset_in_strobe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
